// File: rtl/sram2rw_req_ctrl.sv
// Two-port (2RW) SRAM initiator: ready/valid request channels to active-low macro pins, read data back on buffered response channels.
// Latency: macro pins driven combinationally on fire; read data valid on rsp*_valid two edges after the request is accepted.
// Backpressure: reads are withheld by per-port credit (buffer + in-flight); writes always proceed; port 2 stalls on a same-address conflict with a write.

// Small generic FIFO. The head entry is read straight out of the storage registers.
// Latency: a pushed word is visible on out_dat one edge after the push.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module sram2rw_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push_vld,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop_rdy,
  output logic                   out_vld,
  output logic [W-1:0]           out_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop_rdy & (count != '0);
  assign do_push = push_vld & ((count != (PW+1)'(DEPTH)) | do_pop);

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  assign out_vld = (count != '0);
  assign out_dat = mem[rd_ptr];
endmodule

// One request/response port of the 2RW controller.
// Latency: macro pins follow fire combinationally; read word captured one edge after fire, shown on rsp the same cycle.
// Backpressure: reads need occupancy + in-flight below RSP_DEPTH; block (conflict) forces ready low.
module sram2rw_port #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 16,
  parameter int RSP_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              block,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              sram_csb,
  output logic              sram_web,
  output logic              sram_oeb,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_i,
  input  logic [DATA_W-1:0] sram_o
);
  localparam int CW = $clog2(RSP_DEPTH) + 1;

  logic          inflight;
  logic [CW-1:0] occ;
  logic [CW:0]   pending;
  logic          credit_ok;
  logic          fire;

  // Credit counts only state registered in this block, so rsp_ready never reaches req_ready.
  assign pending   = {1'b0, occ} + {{CW{1'b0}}, inflight};
  assign credit_ok = (pending < (CW+1)'(RSP_DEPTH));
  assign req_ready = reset_n & (req_we | credit_ok) & ~block;
  assign fire      = req_valid & req_ready;

  assign sram_csb = ~fire;
  assign sram_web = ~(fire & req_we);
  assign sram_oeb = ~(fire & ~req_we);
  assign sram_a   = reset_n ? req_addr  : '0;
  assign sram_i   = reset_n ? req_wdata : '0;

  // A read is in flight for exactly the one cycle between its fire edge and its capture edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) inflight <= 1'b0;
    else          inflight <= fire & ~req_we;
  end

  sram2rw_fifo #(
    .W     (DATA_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push_vld (inflight),
    .push_dat (sram_o),
    .pop_rdy  (rsp_ready),
    .out_vld  (rsp_valid),
    .out_dat  (rsp_rdata),
    .count    (occ)
  );
endmodule

// Top: two ports plus cross-port conflict arbitration (port 1 wins).
// Latency: pins combinational from fire; responses two edges after a read fires.
// Backpressure: per-port read credit; port 2 stalls one cycle on a same-address access involving a write.
module sram2rw_req_ctrl #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 16,
  parameter int RSP_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic              req2_valid,
  output logic              req2_ready,
  input  logic              req2_we,
  input  logic [ADDR_W-1:0] req2_addr,
  input  logic [DATA_W-1:0] req2_wdata,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp2_valid,
  input  logic              rsp2_ready,
  output logic [DATA_W-1:0] rsp2_rdata,
  output logic              sram_csb1,
  output logic              sram_web1,
  output logic              sram_oeb1,
  output logic [ADDR_W-1:0] sram_a1,
  output logic [DATA_W-1:0] sram_i1,
  input  logic [DATA_W-1:0] sram_o1,
  output logic              sram_csb2,
  output logic              sram_web2,
  output logic              sram_oeb2,
  output logic [ADDR_W-1:0] sram_a2,
  output logic [DATA_W-1:0] sram_i2,
  input  logic [DATA_W-1:0] sram_o2
);
  logic conflict;

  // Same address with at least one write cannot be issued on both ports; read/read is harmless.
  assign conflict = req1_valid & req2_valid & (req1_addr == req2_addr) & (req1_we | req2_we);

  sram2rw_port #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .RSP_DEPTH (RSP_DEPTH)
  ) u_port1 (
    .clock     (clock),
    .reset_n   (reset_n),
    .block     (1'b0),
    .req_valid (req1_valid),
    .req_ready (req1_ready),
    .req_we    (req1_we),
    .req_addr  (req1_addr),
    .req_wdata (req1_wdata),
    .rsp_valid (rsp1_valid),
    .rsp_ready (rsp1_ready),
    .rsp_rdata (rsp1_rdata),
    .sram_csb  (sram_csb1),
    .sram_web  (sram_web1),
    .sram_oeb  (sram_oeb1),
    .sram_a    (sram_a1),
    .sram_i    (sram_i1),
    .sram_o    (sram_o1)
  );

  sram2rw_port #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .RSP_DEPTH (RSP_DEPTH)
  ) u_port2 (
    .clock     (clock),
    .reset_n   (reset_n),
    .block     (conflict),
    .req_valid (req2_valid),
    .req_ready (req2_ready),
    .req_we    (req2_we),
    .req_addr  (req2_addr),
    .req_wdata (req2_wdata),
    .rsp_valid (rsp2_valid),
    .rsp_ready (rsp2_ready),
    .rsp_rdata (rsp2_rdata),
    .sram_csb  (sram_csb2),
    .sram_web  (sram_web2),
    .sram_oeb  (sram_oeb2),
    .sram_a    (sram_a2),
    .sram_i    (sram_i2),
    .sram_o    (sram_o2)
  );
endmodule

// File: tb/tb_sram2rw_req_ctrl.sv
// Bench for sram2rw_req_ctrl: behavioural macro, reference model of accepted reads,
// table of single-cycle pin vectors, hand sequences for latency/credit/reset, random traffic.
module tb_sram2rw_req_ctrl;
  localparam int RSP_DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req1_valid = 0, req1_we = 0, req2_valid = 0, req2_we = 0;
  logic [6:0]  req1_addr = '0, req2_addr = '0;
  logic [15:0] req1_wdata = '0, req2_wdata = '0;
  logic        req1_ready, req2_ready;
  logic        rsp1_valid, rsp2_valid;
  logic        rsp1_ready = 0, rsp2_ready = 0;
  logic [15:0] rsp1_rdata, rsp2_rdata;
  logic        sram_csb1, sram_web1, sram_oeb1, sram_csb2, sram_web2, sram_oeb2;
  logic [6:0]  sram_a1, sram_a2;
  logic [15:0] sram_i1, sram_i2;
  logic [15:0] sram_o1 = '0, sram_o2 = '0;

  sram2rw_req_ctrl #(.ADDR_W(7), .DATA_W(16), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req2_valid(req2_valid), .req2_ready(req2_ready), .req2_we(req2_we),
    .req2_addr(req2_addr), .req2_wdata(req2_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rdata(rsp1_rdata),
    .rsp2_valid(rsp2_valid), .rsp2_ready(rsp2_ready), .rsp2_rdata(rsp2_rdata),
    .sram_csb1(sram_csb1), .sram_web1(sram_web1), .sram_oeb1(sram_oeb1),
    .sram_a1(sram_a1), .sram_i1(sram_i1), .sram_o1(sram_o1),
    .sram_csb2(sram_csb2), .sram_web2(sram_web2), .sram_oeb2(sram_oeb2),
    .sram_a2(sram_a2), .sram_i2(sram_i2), .sram_o2(sram_o2)
  );

  always #5 clock = ~clock;

  // Behavioural 2RW macro: output only meaningful in the cycle after a read, garbage otherwise.
  logic [15:0] macro_mem [128] = '{default: 16'h0};
  always @(posedge clock) begin
    if (!sram_csb1 && !sram_web1) macro_mem[sram_a1] <= sram_i1;
    if (!sram_csb2 && !sram_web2) macro_mem[sram_a2] <= sram_i2;
    sram_o1 <= (!sram_csb1 && !sram_oeb1) ? macro_mem[sram_a1] : 16'($urandom);
    sram_o2 <= (!sram_csb2 && !sram_oeb2) ? macro_mem[sram_a2] : 16'($urandom);
  end

  // Reference model: memory contents and the list of accepted-but-undelivered reads per port.
  typedef struct { logic [15:0] d; int t; } rd_t;
  rd_t         q1[$], q2[$];
  logic [15:0] ref_mem [128] = '{default: 16'h0};
  int          cyc = 0;
  int          total = 0, bad = 0;
  logic        last_f1 = 0, last_f2 = 0;
  int          delivered1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle with inputs already driven: check against model, clock, update model.
  task automatic cycle();
    logic conf, er1, er2, ef1, ef2, ev1, ev2;
    #1;
    conf = req1_valid && req2_valid && (req1_addr == req2_addr) && (req1_we || req2_we);
    er1  = req1_we || (q1.size() < RSP_DEPTH);
    er2  = (req2_we || (q2.size() < RSP_DEPTH)) && !conf;
    ef1  = req1_valid && er1;
    ef2  = req2_valid && er2;
    chk("req1_ready", 32'(req1_ready), 32'(er1));
    chk("req2_ready", 32'(req2_ready), 32'(er2));
    chk("csb1", 32'(sram_csb1), 32'(!ef1));
    chk("csb2", 32'(sram_csb2), 32'(!ef2));
    chk("web1", 32'(sram_web1), 32'(!(ef1 && req1_we)));
    chk("web2", 32'(sram_web2), 32'(!(ef2 && req2_we)));
    chk("oeb1", 32'(sram_oeb1), 32'(!(ef1 && !req1_we)));
    chk("oeb2", 32'(sram_oeb2), 32'(!(ef2 && !req2_we)));
    chk("a1", 32'(sram_a1), 32'(req1_addr));
    chk("a2", 32'(sram_a2), 32'(req2_addr));
    chk("i1", 32'(sram_i1), 32'(req1_wdata));
    chk("i2", 32'(sram_i2), 32'(req2_wdata));
    ev1 = (q1.size() > 0) && (cyc >= q1[0].t + 1);
    ev2 = (q2.size() > 0) && (cyc >= q2[0].t + 1);
    chk("rsp1_valid", 32'(rsp1_valid), 32'(ev1));
    chk("rsp2_valid", 32'(rsp2_valid), 32'(ev2));
    if (ev1) chk("rsp1_rdata", 32'(rsp1_rdata), 32'(q1[0].d));
    if (ev2) chk("rsp2_rdata", 32'(rsp2_rdata), 32'(q2[0].d));
    last_f1 = ef1;
    last_f2 = ef2;
    @(posedge clock);
    cyc++;
    if (ev1 && rsp1_ready) begin void'(q1.pop_front()); delivered1++; end
    if (ev2 && rsp2_ready) void'(q2.pop_front());
    if (ef1 && !req1_we) q1.push_back('{ref_mem[req1_addr], cyc});
    if (ef2 && !req2_we) q2.push_back('{ref_mem[req2_addr], cyc});
    if (ef1 && req1_we) ref_mem[req1_addr] = req1_wdata;
    if (ef2 && req2_we) ref_mem[req2_addr] = req2_wdata;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    req1_valid = 0; req2_valid = 0; rsp1_ready = 1; rsp2_ready = 1;
    repeat (n) cycle();
  endtask

  task automatic wr1(input logic [6:0] a, input logic [15:0] d);
    req1_valid = 1; req1_we = 1; req1_addr = a; req1_wdata = d;
    cycle();
    req1_valid = 0;
  endtask

  typedef struct {
    logic v1; logic we1; logic [6:0] a1; logic [15:0] d1;
    logic v2; logic we2; logic [6:0] a2; logic [15:0] d2;
    logic rdy1; logic rdy2; logic csb1; logic csb2;
    logic web1; logic web2; logic oeb1; logic oeb2;
  } vec_t;
  localparam int NV = 14;
  vec_t vec [NV];

  initial begin
    int n;
    vec[0]  = '{1'b0,1'b0,7'h00,16'h0000, 1'b0,1'b0,7'h00,16'h0000, 1'b1,1'b1, 1'b1,1'b1, 1'b1,1'b1, 1'b1,1'b1};
    vec[1]  = '{1'b1,1'b1,7'h05,16'hBEEF, 1'b0,1'b0,7'h00,16'h0000, 1'b1,1'b1, 1'b0,1'b1, 1'b0,1'b1, 1'b1,1'b1};
    vec[2]  = '{1'b0,1'b0,7'h00,16'h0000, 1'b1,1'b0,7'h05,16'h0000, 1'b1,1'b1, 1'b1,1'b0, 1'b1,1'b1, 1'b1,1'b0};
    vec[3]  = '{1'b1,1'b1,7'h7F,16'hAAAA, 1'b1,1'b1,7'h7F,16'h5555, 1'b1,1'b0, 1'b0,1'b1, 1'b0,1'b1, 1'b1,1'b1};
    vec[4]  = '{1'b0,1'b0,7'h00,16'h0000, 1'b1,1'b1,7'h7F,16'h5555, 1'b1,1'b1, 1'b1,1'b0, 1'b1,1'b0, 1'b1,1'b1};
    vec[5]  = '{1'b1,1'b0,7'h7F,16'h0000, 1'b1,1'b0,7'h7F,16'h0000, 1'b1,1'b1, 1'b0,1'b0, 1'b1,1'b1, 1'b0,1'b0};
    vec[6]  = '{1'b1,1'b1,7'h20,16'hCAFE, 1'b0,1'b0,7'h00,16'h0000, 1'b1,1'b1, 1'b0,1'b1, 1'b0,1'b1, 1'b1,1'b1};
    vec[7]  = '{1'b1,1'b0,7'h20,16'h0000, 1'b1,1'b1,7'h21,16'h0123, 1'b1,1'b1, 1'b0,1'b0, 1'b1,1'b0, 1'b0,1'b1};
    vec[8]  = '{1'b1,1'b0,7'h30,16'h0000, 1'b1,1'b1,7'h30,16'h4444, 1'b1,1'b0, 1'b0,1'b1, 1'b1,1'b1, 1'b0,1'b1};
    vec[9]  = '{1'b0,1'b1,7'h30,16'h0000, 1'b1,1'b1,7'h30,16'h4444, 1'b1,1'b1, 1'b1,1'b0, 1'b1,1'b0, 1'b1,1'b1};
    vec[10] = '{1'b1,1'b1,7'h40,16'h7777, 1'b1,1'b0,7'h40,16'h0000, 1'b1,1'b0, 1'b0,1'b1, 1'b0,1'b1, 1'b1,1'b1};
    vec[11] = '{1'b1,1'b0,7'h21,16'h0000, 1'b1,1'b0,7'h7F,16'h0000, 1'b1,1'b1, 1'b0,1'b0, 1'b1,1'b1, 1'b0,1'b0};
    vec[12] = '{1'b0,1'b0,7'h00,16'h0000, 1'b1,1'b1,7'h10,16'h1234, 1'b1,1'b1, 1'b1,1'b0, 1'b1,1'b0, 1'b1,1'b1};
    vec[13] = '{1'b1,1'b0,7'h10,16'h0000, 1'b1,1'b0,7'h10,16'h0000, 1'b1,1'b1, 1'b0,1'b0, 1'b1,1'b1, 1'b0,1'b0};

    // Reset state, with requests presented so the gating is exercised.
    req1_valid = 1; req1_we = 1; req1_addr = 7'h05; req1_wdata = 16'h1234;
    req2_valid = 1; req2_we = 0; req2_addr = 7'h06; req2_wdata = 16'h5678;
    #2;
    chk("rst_req1_ready", 32'(req1_ready), 0);
    chk("rst_req2_ready", 32'(req2_ready), 0);
    chk("rst_rsp_valid", 32'({rsp1_valid, rsp2_valid}), 0);
    chk("rst_csb", 32'({sram_csb1, sram_csb2}), 32'h3);
    chk("rst_web", 32'({sram_web1, sram_web2}), 32'h3);
    chk("rst_oeb", 32'({sram_oeb1, sram_oeb2}), 32'h3);
    chk("rst_a", 32'({sram_a1, sram_a2}), 0);
    chk("rst_i", 32'({sram_i1, sram_i2}), 0);
    req1_valid = 0; req2_valid = 0;
    @(negedge clock);
    reset_n = 1;
    idle(2);

    // Single-cycle pin vectors, each from an empty-buffer state.
    for (int k = 0; k < NV; k++) begin
      req1_valid = vec[k].v1; req1_we = vec[k].we1; req1_addr = vec[k].a1; req1_wdata = vec[k].d1;
      req2_valid = vec[k].v2; req2_we = vec[k].we2; req2_addr = vec[k].a2; req2_wdata = vec[k].d2;
      #1;
      chk($sformatf("vec%0d_rdy", k), 32'({req1_ready, req2_ready}), 32'({vec[k].rdy1, vec[k].rdy2}));
      chk($sformatf("vec%0d_csb", k), 32'({sram_csb1, sram_csb2}), 32'({vec[k].csb1, vec[k].csb2}));
      chk($sformatf("vec%0d_web", k), 32'({sram_web1, sram_web2}), 32'({vec[k].web1, vec[k].web2}));
      chk($sformatf("vec%0d_oeb", k), 32'({sram_oeb1, sram_oeb2}), 32'({vec[k].oeb1, vec[k].oeb2}));
      cycle();
      idle(3);
    end

    // Write then read on the other port: response appears two edges after the read fires.
    wr1(7'h05, 16'hBEEF);
    req2_valid = 1; req2_we = 0; req2_addr = 7'h05; rsp2_ready = 0;
    cycle();
    req2_valid = 0;
    #1 chk("lat_one_edge", 32'(rsp2_valid), 0);
    cycle();
    #1 chk("lat_two_edges", 32'(rsp2_valid), 1);
    chk("lat_data", 32'(rsp2_rdata), 32'h0000BEEF);
    idle(3);

    // Credit: four reads against a stalled consumer, then drain in order.
    for (int k = 0; k < 4; k++) wr1(7'(k), 16'(16'h1000 + k));
    idle(2);
    delivered1 = 0;
    n = 0;
    rsp1_ready = 0; req1_valid = 1; req1_we = 0;
    for (int k = 0; k < 6; k++) begin
      req1_addr = 7'(n);
      cycle();
      if (last_f1) n++;
    end
    chk("credit_accepted", 32'(n), 2);
    #1 chk("credit_ready_low", 32'(req1_ready), 0);
    rsp1_ready = 1;
    for (int k = 0; k < 20 && n < 4; k++) begin
      req1_addr = 7'(n);
      cycle();
      if (last_f1) n++;
    end
    chk("credit_all_accepted", 32'(n), 4);
    idle(6);
    chk("credit_delivered", 32'(delivered1), 4);
    chk("credit_q_empty", 32'(q1.size()), 0);

    // Reset between a read fire and its capture edge.
    rsp1_ready = 0; req1_valid = 1; req1_we = 0; req1_addr = 7'h10;
    cycle();
    req1_addr = 7'h11;
    cycle();
    reset_n = 0;
    req1_valid = 0;
    #1;
    chk("midrst_rsp1_valid", 32'(rsp1_valid), 0);
    chk("midrst_csb", 32'({sram_csb1, sram_csb2}), 32'h3);
    chk("midrst_ready", 32'(req1_ready), 0);
    q1.delete(); q2.delete();
    @(posedge clock);
    @(negedge clock);
    reset_n = 1;
    #1 chk("postrst_ready", 32'(req1_ready), 1);
    idle(5);

    // Random traffic on a small address window to provoke conflicts.
    for (int k = 0; k < 1500; k++) begin
      req1_valid = ($urandom_range(0, 9) < 7); req1_we = $urandom_range(0, 1) == 1;
      req1_addr = 7'($urandom_range(0, 7)); req1_wdata = 16'($urandom);
      req2_valid = ($urandom_range(0, 9) < 7); req2_we = $urandom_range(0, 1) == 1;
      req2_addr = 7'($urandom_range(0, 7)); req2_wdata = 16'($urandom);
      rsp1_ready = ($urandom_range(0, 9) < 6); rsp2_ready = ($urandom_range(0, 9) < 6);
      cycle();
    end
    idle(8);
    chk("rand_q1_drained", 32'(q1.size()), 0);
    chk("rand_q2_drained", 32'(q2.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
